fsm_cmd_responder: RTL and testbench
====================================

Name: fsm_cmd_responder

Overview:
- Responder end of the controller-FSM command interface.
- A controller FSM issues single commands over a valid/ready request channel: WRITE, READ, CLEAR or NOP.
- The block executes each command against a local register bank over a fixed multi-cycle latency, then returns data and status on a valid/ready response channel.
- It sits beside the top-level sequencer as its register and key-word store.

Parameters:
- DATA_W, 32: register and data width in bits.
- ADDR_W, 4: request address width.
- DEPTH, 8: number of registers. Must satisfy 1 <= DEPTH <= 2**ADDR_W.
- OP_LAT, 4: execute cycles for WRITE, READ and NOP. Must be >= 1.

Ports:
- clk, input, 1: clock. All logic on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- req_valid, input, 1: command present.
- req_ready, output, 1: block can accept a command. High only in IDLE.
- req_op, input, 2: command code. 00 NOP, 01 WRITE, 10 READ, 11 CLEAR.
- req_addr, input, ADDR_W: register index.
- req_wdata, input, DATA_W: write data.
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: controller accepts the response.
- rsp_rdata, output, DATA_W: read data. 0 for non-READ commands and on error.
- rsp_err, output, 1: address error flag.
- busy, output, 1: high in EXEC or RESP.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE.
  - All DEPTH registers cleared to 0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=0 while rst is high.
  - Internal counter 0.
- States: IDLE, EXEC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge T: capture op, addr and wdata into registers, load the counter, go to EXEC.
  - Request inputs are ignored outside the accept edge.
- EXEC, WRITE/READ/NOP:
  - Lasts exactly OP_LAT cycles (cycles T+1..T+OP_LAT).
  - On the final EXEC cycle: WRITE updates reg[addr]; READ samples reg[addr] into rsp_rdata.
  - Then go to RESP.
- EXEC, CLEAR:
  - Lasts exactly DEPTH cycles.
  - Clears reg[i] on EXEC cycle i+1, for i=0..DEPTH-1.
  - Then go to RESP. req_addr is ignored.
- Address error:
  - Applies to WRITE or READ with captured addr >= DEPTH.
  - No register is modified; rsp_rdata=0; rsp_err=1.
  - EXEC length is unchanged.
- RESP:
  - rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid && rsp_ready.
  - Returns to IDLE on that edge; rsp_valid deasserts the next cycle.
  - rsp_ready may be held low indefinitely.
  - rsp_rdata and rsp_err keep their last values in IDLE; only rsp_valid qualifies them.
- Latency:
  - rsp_valid first high in cycle T+OP_LAT+1 (CLEAR: T+DEPTH+1).
  - Minimum command-to-command spacing is OP_LAT+2 cycles, given rsp_ready=1.
- No pipelining: exactly one command outstanding. req_ready=0 in EXEC and RESP.
- req_valid asserted in the same cycle as the RESP handshake: not accepted until the IDLE cycle that follows.
- Reset mid-operation:
  - The in-flight command is discarded.
  - A WRITE whose final EXEC edge has not occurred has no effect.
  - A partially complete CLEAR is superseded by the reset clear.
- Counter width: clog2(max(OP_LAT, DEPTH)) + 1 bits. No wrap-around is permitted.
- Illegal state encodings recover to IDLE with rsp_valid=0.

Optional Feature:
- Macro: FSM_CMD_RESPONDER_PARITY_EN.
- Defined:
  - Adds output rsp_parity (1 bit) = even parity (XOR reduction) of rsp_rdata.
  - Registered in the same edge as rsp_rdata and held with it.
  - Reset value 0.
  - Adds input req_parity (1 bit), checked against req_wdata on WRITE at the accept edge.
  - On mismatch: rsp_err=1 and the write is suppressed.
- Undefined: neither port exists; no parity logic is present.

Test Plan:
- WRITE 0xDEADBEEF to addr 3 accepted at T, rsp_ready=1 (OP_LAT=4) -> rsp_valid at T+5, rsp_err=0, rsp_rdata=0. Then READ addr 3 -> rsp_rdata=0xDEADBEEF.
- READ addr 9 (DEPTH=8) -> rsp_err=1, rsp_rdata=0, rsp_valid at T+5. A prior READ of every register shows no change.
- Response backpressure: READ, then hold rsp_ready=0 for 10 cycles -> rsp_valid, rsp_rdata and rsp_err stable, req_ready=0, busy=1. Raise rsp_ready -> IDLE next cycle.
- WRITE 0x11..0x88 to addrs 0..7, then CLEAR -> rsp_valid at T+9. READs of all 8 addrs return 0.
- Assert rst during the third EXEC cycle of WRITE 0xA5A5A5A5 to addr 2 -> outputs at reset values immediately. After release, READ addr 2 returns 0 and req_ready=1 the first cycle out of reset.
- With FSM_CMD_RESPONDER_PARITY_EN: READ of 0x00000007 -> rsp_parity=1. WRITE 0x3 with req_parity=1 -> rsp_err=1 and the register is unchanged.

Source files
------------

// File: rtl/fsm_cmd_responder.sv
// ============================================================================
// Module   : fsm_cmd_responder
// Purpose  : Single-outstanding command responder: WRITE/READ/CLEAR/NOP
//            against a local register bank, valid/ready request and response.
// Option   : FSM_CMD_RESPONDER_PARITY_EN adds req_parity / rsp_parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fsm_cmd_responder #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8,
  parameter int OP_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
`ifdef FSM_CMD_RESPONDER_PARITY_EN
  input  logic              req_parity,
  output logic              rsp_parity,
`endif
  output logic              busy
);

  localparam int MAX_CNT = (OP_LAT > DEPTH) ? OP_LAT : DEPTH;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;

  localparam logic [1:0] c_op_write = 2'b01;
  localparam logic [1:0] c_op_read  = 2'b10;
  localparam logic [1:0] c_op_clear = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                perr_q;
  logic [DATA_W-1:0]   regs_q [DEPTH];

  logic                w_accept;
  logic                w_last;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata;

  assign w_accept = (state_q == S_IDLE) && req_valid;
  assign w_last   = (state_q == S_EXEC) && (cnt_q == CNT_W'(1));
  assign w_err    = (((op_q == c_op_write) || (op_q == c_op_read)) &&
                     (int'(addr_q) >= DEPTH)) || perr_q;

  always_comb begin
    w_rdata = '0;
    if ((op_q == c_op_read) && !w_err) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (addr_q == ADDR_W'(i)) w_rdata = regs_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; unused encoding falls back to IDLE.
  always_comb begin
    state_d   = S_IDLE;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = !rst;
        state_d   = w_accept ? S_EXEC : S_IDLE;
      end
      S_EXEC: begin
        busy    = 1'b1;
        state_d = w_last ? S_RESP : S_EXEC;
      end
      S_RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        state_d   = rsp_ready ? S_IDLE : S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      perr_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (w_accept) begin
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      cnt_q   <= (req_op == c_op_clear) ? CNT_W'(DEPTH) : CNT_W'(OP_LAT);
`ifdef FSM_CMD_RESPONDER_PARITY_EN
      perr_q  <= (req_op == c_op_write) && (req_parity != ^req_wdata);
`else
      perr_q  <= 1'b0;
`endif
    end else if (state_q == S_EXEC) begin
      cnt_q <= cnt_q - CNT_W'(1);
      // CLEAR walks the bank: register i is cleared on EXEC cycle i+1.
      if (op_q == c_op_clear) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (cnt_q == CNT_W'(DEPTH - i)) regs_q[i] <= '0;
        end
      end
      if (w_last) begin
        rdata_q <= w_rdata;
        err_q   <= w_err;
        if ((op_q == c_op_write) && !w_err) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (addr_q == ADDR_W'(i)) regs_q[i] <= wdata_q;
          end
        end
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

`ifdef FSM_CMD_RESPONDER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         parity_q <= 1'b0;
    else if (w_last) parity_q <= ^w_rdata;
  end

  assign rsp_parity = parity_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fsm_cmd_responder.sv
// ============================================================================
// Module   : tb_fsm_cmd_responder
// Purpose  : Scoreboard bench for fsm_cmd_responder with a behavioural
//            register-bank model and randomized command traffic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fsm_cmd_responder;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int DEP = 8;
  localparam int LAT = 4;

  localparam logic [1:0] c_nop = 2'b00;
  localparam logic [1:0] c_wr  = 2'b01;
  localparam logic [1:0] c_rd  = 2'b10;
  localparam logic [1:0] c_clr = 2'b11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
`ifdef FSM_CMD_RESPONDER_PARITY_EN
  logic          req_parity = 1'b0;
  logic          rsp_parity;
  bit            bad_par_g = 1'b0;
`endif

  fsm_cmd_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .OP_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
`ifdef FSM_CMD_RESPONDER_PARITY_EN
    .req_parity(req_parity),
    .rsp_parity(rsp_parity),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rd;
    logic          err;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] mem [DEP];
  int            checks = 0;
  int            errors = 0;
  bit            rr_rand = 1'b0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference model: commands complete in issue order, so the expected
  // response can be computed from the bank state at issue time.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   perr;
    bit   bad;
    int   n;
    perr  = 1'b0;
`ifdef FSM_CMD_RESPONDER_PARITY_EN
    perr       = (op == c_wr) && bad_par_g;
    req_parity = (^d) ^ bad_par_g;
`endif
    bad   = int'(a) >= DEP;
    e.rd  = '0;
    e.err = 1'b0;
    e.lat = LAT;
    case (op)
      c_wr: begin
        e.err = bad || perr;
        if (!e.err) mem[int'(a)] = d;
      end
      c_rd: begin
        e.err = bad;
        if (!bad) e.rd = mem[int'(a)];
      end
      c_clr: begin
        e.lat = DEP;
        for (int i = 0; i < DEP; i++) mem[i] = '0;
      end
      default: ;
    endcase
    exp_q.push_back(e);
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) chk("issue_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || !req_ready) && n < 300);
    if (exp_q.size() != 0 || !req_ready) chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Background response backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_rand) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, hold-stability and scoreboard compare on handshake.
  initial begin
    int            k;
    bit            pend;
    bit            seen;
    logic [DW-1:0] prd;
    logic          perr;
    exp_t          e;
    k = 0; pend = 0; seen = 0; prd = '0; perr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        seen = 0;
      end else begin
        if (pend) k++;
        if (rsp_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            if (!seen) begin
              seen = 1;
              chk("rsp_after_accept", 32'(pend), 32'd1);
              chk("latency", 32'(k), 32'(exp_q[0].lat + 1));
              prd  = rsp_rdata;
              perr = rsp_err;
            end else begin
              chk("hold_rdata", rsp_rdata, prd);
              chk("hold_err", 32'(rsp_err), 32'(perr));
            end
            chk("resp_ready_busy", {30'd0, req_ready, busy}, 32'd1);
            if (rsp_ready) begin
              e = exp_q.pop_front();
              chk("rsp_rdata", rsp_rdata, e.rd);
              chk("rsp_err", 32'(rsp_err), 32'(e.err));
`ifdef FSM_CMD_RESPONDER_PARITY_EN
              chk("rsp_parity", 32'(rsp_parity), 32'(^e.rd));
`endif
              seen = 0;
              pend = 0;
            end
          end
        end
        if (req_valid && req_ready) begin
          pend = 1;
          k    = 0;
        end
      end
    end
  end

  initial begin
    #1000000;
    chk("watchdog", 32'd1, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    for (int i = 0; i < DEP; i++) mem[i] = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // Write then read back.
    issue(c_wr, 4'd3, 32'hDEADBEEF);
    issue(c_rd, 4'd3, 32'h0);
    // Every register, then an out-of-range read, then every register again.
    for (int i = 0; i < DEP; i++) issue(c_rd, AW'(i), $urandom);
    issue(c_rd, 4'd9, 32'h0);
    issue(c_wr, 4'd12, 32'h12345678);
    for (int i = 0; i < DEP; i++) issue(c_rd, AW'(i), $urandom);
    issue(c_nop, 4'd0, 32'h0);
    wait_idle();

    // Response backpressure for ten cycles.
    rsp_ready = 1'b0;
    issue(c_rd, 4'd3, 32'h0);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", {30'd0, rsp_valid, req_ready}, 32'd1);
    wait_idle();

    // Fill then CLEAR.
    for (int i = 0; i < DEP; i++) issue(c_wr, AW'(i), 32'h11 * (i + 1));
    issue(c_clr, 4'd5, 32'h0);
    for (int i = 0; i < DEP; i++) issue(c_rd, AW'(i), 32'h0);
    wait_idle();

`ifdef FSM_CMD_RESPONDER_PARITY_EN
    issue(c_wr, 4'd1, 32'h00000007);
    issue(c_rd, 4'd1, 32'h0);
    bad_par_g = 1'b1;
    issue(c_wr, 4'd1, 32'h00000003);
    bad_par_g = 1'b0;
    issue(c_rd, 4'd1, 32'h0);
    wait_idle();
`endif

    // Randomized traffic with random backpressure.
    rr_rand = 1'b1;
    for (int t = 0; t < 80; t++) begin
      int r;
      logic [1:0] op;
      r  = $urandom_range(0, 9);
      op = (r == 0) ? c_clr : (r == 1) ? c_nop : (r < 6) ? c_wr : c_rd;
`ifdef FSM_CMD_RESPONDER_PARITY_EN
      bad_par_g = ($urandom_range(0, 7) == 0);
`endif
      issue(op, AW'($urandom_range(0, 11)), $urandom);
    end
`ifdef FSM_CMD_RESPONDER_PARITY_EN
    bad_par_g = 1'b0;
`endif
    wait_idle();
    rr_rand   = 1'b0;
    rsp_ready = 1'b1;
    issue(c_wr, 4'd2, 32'h0BADF00D);
    wait_idle();

    // Reset during the third EXEC cycle of a WRITE.
    req_op    = c_wr;
    req_addr  = 4'd2;
    req_wdata = 32'hA5A5A5A5;
    req_valid = 1'b1;
    @(negedge clk);
    chk("mr_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_req_ready", 32'(req_ready), 32'd0);
    chk("mr_rsp_rdata", rsp_rdata, 32'd0);
    chk("mr_rsp_err", 32'(rsp_err), 32'd0);
    for (int i = 0; i < DEP; i++) mem[i] = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mr_ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    issue(c_rd, 4'd2, 32'h0);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
